// File: rtl/multichannel_delay_store.sv
// N-channel circular delay line in external SDRAM behind a read/write/busy/rvalid controller handshake.
// Optional memory-handshake watchdog: define MULTICHANNEL_DELAY_STORE_TIMEOUT_EN.
module multichannel_delay_store #(
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 16,
   parameter int CH_W        = 1,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                     clk50,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] idata,
   input  logic [CH_W-1:0]          ichan,
   input  logic                     ivalid,
   output logic                     iready,
   input  logic [ADDR_W-CH_W-1:0]   delay,
   output logic signed [DATA_W-1:0] odata,
   output logic [CH_W-1:0]          ochan,
   output logic                     ovalid,
   input  logic                     oready,
   input  logic                     lrclk,
   output logic                     mem_write,
   output logic                     mem_read,
   output logic [ADDR_W-1:0]        mem_waddr,
   output logic [ADDR_W-1:0]        mem_raddr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_busy,
   input  logic                     mem_rvalid,
   output logic                     err,
   output logic [3:0]               state
);

   localparam int PTR_W = ADDR_W - CH_W;
   localparam int NCH   = 1 << CH_W;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LATCH   = 4'd1,
      WR_REQ  = 4'd2,
      WR_ACK  = 4'd3,
      WR_DONE = 4'd4,
      RD_REQ  = 4'd5,
      RD_ACK  = 4'd6,
      RD_WAIT = 4'd7,
      OUT     = 4'd8
   } state_t;

   state_t                   st, st_nxt;
   logic [PTR_W-1:0]         wptr [NCH];
   logic [PTR_W-1:0]         fill [NCH];
   logic [PTR_W-1:0]         rptr, d_l;
   logic [CH_W-1:0]          ch_l;
   logic signed [DATA_W-1:0] data_l;
   logic                     busy_q;
   logic                     accept, advance, out_direct, rd_cap;
   logic                     wr_nxt, rd_nxt, ov_nxt;

   assign mem_waddr = {ch_l, wptr[ch_l]};
   assign mem_raddr = {ch_l, rptr};
   assign mem_wdata = data_l;
   assign state     = st;

`ifdef MULTICHANNEL_DELAY_STORE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tcnt;
   logic             tmo, to_fire;

   assign tmo = (st >= WR_REQ) && (st <= RD_WAIT) && (tcnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk50) begin
      if (rst || st_nxt != st || st < WR_REQ || st > RD_WAIT)
         tcnt <= '0;
      else
         tcnt <= tcnt + 1'b1;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
   assign err = 1'b0;
`endif

   always_comb begin
      st_nxt     = st;
      accept     = 1'b0;
      advance    = 1'b0;
      out_direct = 1'b0;
      rd_cap     = 1'b0;
      wr_nxt     = 1'b0;
      rd_nxt     = 1'b0;
      ov_nxt     = 1'b0;
      unique case (st)
         IDLE:    if (ivalid) begin accept = 1'b1; st_nxt = LATCH; end
         LATCH:   st_nxt = WR_REQ;
         WR_REQ:  if (!mem_busy && lrclk) begin wr_nxt = 1'b1; st_nxt = WR_ACK; end
         WR_ACK:  if (mem_busy && !busy_q) st_nxt = WR_DONE; else wr_nxt = 1'b1;
         WR_DONE: if (!mem_busy) begin
            advance = 1'b1;
            // Zero delay bypasses the read; an unprimed line outputs silence.
            if (d_l == '0 || fill[ch_l] < d_l) begin
               out_direct = 1'b1;
               ov_nxt     = 1'b1;
               st_nxt     = OUT;
            end else begin
               st_nxt = RD_REQ;
            end
         end
         RD_REQ:  if (!mem_busy && lrclk) begin rd_nxt = 1'b1; st_nxt = RD_ACK; end
         RD_ACK:  if (mem_busy && !busy_q) st_nxt = RD_WAIT; else rd_nxt = 1'b1;
         RD_WAIT: if (mem_rvalid) begin rd_cap = 1'b1; ov_nxt = 1'b1; st_nxt = OUT; end
         OUT:     if (oready) st_nxt = IDLE; else ov_nxt = 1'b1;
         default: st_nxt = IDLE;
      endcase
`ifdef MULTICHANNEL_DELAY_STORE_TIMEOUT_EN
      to_fire = 1'b0;
      // Only a stalled state times out, so a completing WR_DONE always advances pointers.
      if (tmo && st_nxt == st) begin
         to_fire = 1'b1;
         wr_nxt  = 1'b0;
         rd_nxt  = 1'b0;
         ov_nxt  = 1'b1;
         st_nxt  = OUT;
      end
`endif
   end

   always_ff @(posedge clk50) begin
      if (rst) begin
         st        <= IDLE;
         busy_q    <= 1'b0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         iready    <= 1'b0;
         ovalid    <= 1'b0;
         odata     <= '0;
         ochan     <= '0;
         data_l    <= '0;
         ch_l      <= '0;
         d_l       <= '0;
         rptr      <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            wptr[i] <= '0;
            fill[i] <= '0;
         end
`ifdef MULTICHANNEL_DELAY_STORE_TIMEOUT_EN
         err <= 1'b0;
`endif
      end else begin
         st        <= st_nxt;
         busy_q    <= mem_busy;
         mem_write <= wr_nxt;
         mem_read  <= rd_nxt;
         iready    <= accept;
         ovalid    <= ov_nxt;
         if (accept) begin
            data_l <= idata;
            ch_l   <= ichan;
            d_l    <= delay;   // PTR_W-wide, so already capped at D-1
         end
         if (st == LATCH)
            rptr <= wptr[ch_l] - d_l;
         if (advance) begin
            wptr[ch_l] <= wptr[ch_l] + 1'b1;
            if (fill[ch_l] != '1)
               fill[ch_l] <= fill[ch_l] + 1'b1;
         end
         if (out_direct) begin
            odata <= (d_l == '0) ? data_l : '0;
            ochan <= ch_l;
         end
         if (rd_cap) begin
            odata <= mem_rdata;
            ochan <= ch_l;
         end
`ifdef MULTICHANNEL_DELAY_STORE_TIMEOUT_EN
         if (to_fire) begin
            odata <= '0;
            ochan <= ch_l;
            err   <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_multichannel_delay_store.sv
// Directed bench for multichannel_delay_store: vector table plus hand-written handshake/reset/timeout sequences.
module tb_multichannel_delay_store;

   localparam int ADDR_W = 8;
   localparam int CH_W   = 1;
   localparam int PTR_W  = ADDR_W - CH_W;
   localparam int D      = 1 << PTR_W;

   logic              clk50 = 1'b0;
   logic              rst = 1'b1;
   logic [15:0]       idata = '0;
   logic [CH_W-1:0]   ichan = '0;
   logic              ivalid = 1'b0;
   logic              iready;
   logic [PTR_W-1:0]  delay = '0;
   logic [15:0]       odata;
   logic [CH_W-1:0]   ochan;
   logic              ovalid;
   logic              oready = 1'b0;
   logic              lrclk = 1'b1;
   logic              mem_write, mem_read;
   logic [ADDR_W-1:0] mem_waddr, mem_raddr;
   logic [15:0]       mem_wdata;
   logic [15:0]       rdata_m = '0;
   logic              busy_m = 1'b0, busy_force = 1'b0;
   logic              rvalid_m = 1'b0;
   logic              err;
   logic [3:0]        state;

   multichannel_delay_store #(.ADDR_W(ADDR_W), .DATA_W(16), .CH_W(CH_W), .TIMEOUT_CYC(16)) dut (
      .clk50(clk50), .rst(rst), .idata(idata), .ichan(ichan), .ivalid(ivalid), .iready(iready),
      .delay(delay), .odata(odata), .ochan(ochan), .ovalid(ovalid), .oready(oready), .lrclk(lrclk),
      .mem_write(mem_write), .mem_read(mem_read), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
      .mem_wdata(mem_wdata), .mem_rdata(rdata_m), .mem_busy(busy_m | busy_force),
      .mem_rvalid(rvalid_m), .err(err), .state(state));

   always #10 clk50 = ~clk50;

   // Ideal controller: one-cycle busy pulse per strobe, read data one cycle after busy.
   logic [15:0]       mem [D*2];
   logic              rd_pend = 1'b0, wr_stall = 1'b0, rd_stall = 1'b0;
   logic [ADDR_W-1:0] ra_q = '0, last_wa = '0, last_ra = '0;
   int                rd_count = 0, dual_cnt = 0;

   always @(posedge clk50) begin
      if (mem_write && mem_read) dual_cnt <= dual_cnt + 1;
      rvalid_m <= 1'b0;
      busy_m   <= 1'b0;
      if (rd_pend) begin
         rvalid_m <= 1'b1;
         rdata_m  <= mem[ra_q];
         rd_pend  <= 1'b0;
      end
      if (!busy_m && mem_write && !wr_stall) begin
         busy_m          <= 1'b1;
         mem[mem_waddr]  <= mem_wdata;
         last_wa         <= mem_waddr;
      end else if (!busy_m && mem_read && !rd_stall) begin
         busy_m   <= 1'b1;
         rd_pend  <= 1'b1;
         ra_q     <= mem_raddr;
         last_ra  <= mem_raddr;
         rd_count <= rd_count + 1;
      end
   end

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_iready"}, iready, 0);
      chk({tag, "_ovalid"}, ovalid, 0);
      chk({tag, "_odata"}, odata, 0);
      chk({tag, "_ochan"}, ochan, 0);
      chk({tag, "_mem_write"}, mem_write, 0);
      chk({tag, "_mem_read"}, mem_read, 0);
      chk({tag, "_mem_waddr"}, mem_waddr, 0);
      chk({tag, "_mem_raddr"}, mem_raddr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_state"}, state, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk50);
      rst = 1'b0;
   endtask

   task automatic wait_accept();
      logic got = 1'b0;
      ivalid = 1'b1;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk50);
         got = iready;
      end
      ivalid = 1'b0;
      chk("accept_wait", got, 1);
   endtask

   task automatic xfer(input logic [CH_W-1:0] c, input logic [15:0] dat, input logic [PTR_W-1:0] dl,
                       input int hold, input logic [15:0] hold_exp,
                       output logic [15:0] od, output logic [CH_W-1:0] oc);
      logic got;
      ichan = c; idata = dat; delay = dl;
      wait_accept();
      got = ovalid;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk50);
         got = ovalid;
      end
      chk("ovalid_wait", got, 1);
      od = odata;
      oc = ochan;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk50);
         chk("hold_ovalid", ovalid, 1);
         chk("hold_odata", odata, hold_exp);
      end
      oready = 1'b1;
      @(negedge clk50);
      oready = 1'b0;
   endtask

   typedef struct {
      logic [CH_W-1:0]   ch;
      logic [15:0]       din;
      logic [PTR_W-1:0]  dl;
      logic [15:0]       exp_o;
      logic [ADDR_W-1:0] exp_wa;
      bit                exp_rd;
      logic [ADDR_W-1:0] exp_ra;
      bit                rst_before;
   } vec_t;

   vec_t tbl [13];

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [15:0]     od;
      logic [CH_W-1:0] oc;
      int              rc0, cnt;
      logic            got;

      // single-channel delay 3, then interleaved two-channel delay 2
      tbl[0]  = '{1'b0, 16'd10,    7'd3, 16'd0,     8'h00, 1'b0, 8'h00, 1'b1};
      tbl[1]  = '{1'b0, 16'd20,    7'd3, 16'd0,     8'h01, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 16'd30,    7'd3, 16'd0,     8'h02, 1'b0, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 16'd40,    7'd3, 16'd10,    8'h03, 1'b1, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 16'd50,    7'd3, 16'd20,    8'h04, 1'b1, 8'h01, 1'b0};
      tbl[5]  = '{1'b0, 16'd100,   7'd2, 16'd0,     8'h00, 1'b0, 8'h00, 1'b1};
      tbl[6]  = '{1'b1, 16'hFF9C,  7'd2, 16'd0,     8'h80, 1'b0, 8'h00, 1'b0};
      tbl[7]  = '{1'b0, 16'd100,   7'd2, 16'd0,     8'h01, 1'b0, 8'h00, 1'b0};
      tbl[8]  = '{1'b1, 16'hFF9C,  7'd2, 16'd0,     8'h81, 1'b0, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 16'd100,   7'd2, 16'd100,   8'h02, 1'b1, 8'h00, 1'b0};
      tbl[10] = '{1'b1, 16'hFF9C,  7'd2, 16'hFF9C,  8'h82, 1'b1, 8'h80, 1'b0};
      tbl[11] = '{1'b0, 16'd100,   7'd2, 16'd100,   8'h03, 1'b1, 8'h01, 1'b0};
      tbl[12] = '{1'b1, 16'hFF9C,  7'd2, 16'hFF9C,  8'h83, 1'b1, 8'h81, 1'b0};

      repeat (3) @(negedge clk50);
      chk_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         if (tbl[i].rst_before) do_reset();
         rc0 = rd_count;
         xfer(tbl[i].ch, tbl[i].din, tbl[i].dl, 0, 16'd0, od, oc);
         chk($sformatf("v%0d_odata", i), od, tbl[i].exp_o);
         chk($sformatf("v%0d_ochan", i), oc, tbl[i].ch);
         chk($sformatf("v%0d_waddr", i), last_wa, tbl[i].exp_wa);
         chk($sformatf("v%0d_read", i), rd_count != rc0, tbl[i].exp_rd);
         if (tbl[i].exp_rd) chk($sformatf("v%0d_raddr", i), last_ra, tbl[i].exp_ra);
      end

      // wrap: sample i carries value i+1 and is written at i mod D
      do_reset();
      for (int i = 0; i < D - 2; i++) xfer(1'b0, 16'(i + 1), 7'd4, 0, 16'd0, od, oc);
      for (int i = D - 2; i < D + 3; i++) begin
         xfer(1'b0, 16'(i + 1), 7'd4, 0, 16'd0, od, oc);
         chk($sformatf("wrap%0d_waddr", i), last_wa, 32'((i) % D));
         chk($sformatf("wrap%0d_raddr", i), last_ra, 32'((i - 4) % D));
         chk($sformatf("wrap%0d_odata", i), od, 32'(i - 3));
      end

      // zero-delay bypass with downstream stall
      rc0 = rd_count;
      xfer(1'b0, 16'h7FFF, 7'd0, 10, 16'h7FFF, od, oc);
      chk("bypass_odata", od, 16'h7FFF);
      chk("bypass_no_read", rd_count - rc0, 0);

      // strobe gating on busy/lrclk, then reset in RD_ACK
      do_reset();
      xfer(1'b1, 16'd555, 7'd1, 0, 16'd0, od, oc);
      chk("prime_silence", od, 0);
      busy_force = 1'b1;
      lrclk = 1'b0;
      rd_stall = 1'b1;
      ichan = 1'b1; idata = 16'd777; delay = 7'd1;
      wait_accept();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk50);
         lrclk = ~lrclk;
         chk("busy_no_wr", mem_write, 0);
      end
      busy_force = 1'b0;
      lrclk = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk50);
         chk("lrclk_low_no_wr", mem_write, 0);
      end
      lrclk = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 4 && !got; n++) begin
         @(negedge clk50);
         got = mem_write;
      end
      chk("wr_after_free", got, 1);
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk50);
         got = (state == 4'd6);
      end
      chk("reach_rd_ack", got, 1);
      chk("rd_ack_mem_read", mem_read, 1);
      chk("rd_ack_raddr", mem_raddr, 8'h80);
      rst = 1'b1;
      @(negedge clk50);
      chk_all_zero("rst_rd_ack");
      rst = 1'b0;
      rd_stall = 1'b0;
      @(negedge clk50);

`ifdef MULTICHANNEL_DELAY_STORE_TIMEOUT_EN
      do_reset();
      wr_stall = 1'b1;
      ichan = 1'b0; idata = 16'd1234; delay = 7'd0;
      wait_accept();
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk50);
         got = mem_write;
      end
      chk("to_write_seen", got, 1);
      cnt = 0;
      while (mem_write && cnt < 40) begin
         cnt++;
         @(negedge clk50);
      end
      chk("to_write_cycles", cnt, 16);
      chk("to_err", err, 1);
      chk("to_ovalid", ovalid, 1);
      chk("to_odata", odata, 0);
      chk("to_state", state, 8);
      oready = 1'b1;
      @(negedge clk50);
      oready = 1'b0;
      wr_stall = 1'b0;
`else
      cnt = 0;
      chk("err_tied_low", err, cnt);
`endif

      chk("no_dual_strobe", dual_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multichannel_delay_store.md
Name: multichannel_delay_store

Overview:
- Parametrised successor to the audio sample-storage block: N-channel circular delay line in external SDRAM, behind the shared memory controller's read/write/busy/read-ready handshake.
- Accepts one sample per channel per frame, writes it at that channel's write pointer, then returns the sample written `delay` frames earlier.
- Sits between the codec deserialiser and the effects chain. Delay length is a runtime input, not fixed at build time.

Parameters:
- ADDR_W, 24, memory word address width.
- DATA_W, 16, signed sample width.
- CH_W, 1, channel index width; channels = 2^CH_W.
- PTR_W = ADDR_W-CH_W (derived, not overridable), per-channel region address width; region depth D = 2^PTR_W.
- TIMEOUT_CYC, 4096, memory handshake watchdog limit. Used only with the optional feature.

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- idata  in  DATA_W  signed input sample.
- ichan  in  CH_W  channel of idata.
- ivalid  in  1  input sample valid.
- iready  out  1  one-cycle accept pulse.
- delay  in  PTR_W  delay in frames; sampled at accept.
- odata  out  DATA_W  delayed sample (signed).
- ochan  out  CH_W  channel of odata.
- ovalid  out  1  output valid.
- oready  in  1  downstream accept.
- lrclk  in  1  codec frame clock; memory ops start only while high.
- mem_write  out  1  write strobe.
- mem_read  out  1  read strobe.
- mem_waddr  out  ADDR_W  {chan, wptr[chan]}.
- mem_raddr  out  ADDR_W  {chan, rptr}.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data.
- mem_busy  in  1  controller busy.
- mem_rvalid  in  1  read data valid.
- err  out  1  sticky watchdog error.
- state  out  4  FSM state, for debug.

Behaviour:
- Reset (synchronous, 1 cycle): all outputs 0; state IDLE; all wptr = 0; all fill counters = 0. If asserted mid-handshake, strobes drop on the next edge and the transaction is abandoned.
- Per-channel storage: wptr[c] (PTR_W bits) and fill[c] (saturates at D-1).
- IDLE(0): when ivalid, pulse iready for 1 cycle; latch idata, ichan, and d = min(delay, D-1); go LATCH.
- LATCH(1): compute rptr = (wptr[c] - d) mod 2^PTR_W, wrapping naturally. Go WR_REQ.
- WR_REQ(2): wait for !mem_busy && lrclk; assert mem_write; go WR_ACK.
- WR_ACK(3): hold mem_write until mem_busy rises (rising edge detected against registered mem_busy); deassert; go WR_DONE.
- WR_DONE(4): wait for !mem_busy. Then:
  - wptr[c] += 1, wrapping D-1 -> 0.
  - fill[c] += 1 (saturating).
  - If d == 0: out = latched idata (bypass, no read); go OUT.
  - Else if fill[c] (pre-increment) < d: out = 0 (silence until the line is primed); go OUT.
  - Else: go RD_REQ.
- RD_REQ(5): wait for !mem_busy && lrclk; assert mem_read; go RD_ACK.
- RD_ACK(6): hold mem_read until mem_busy rises; deassert; go RD_WAIT.
- RD_WAIT(7): on mem_rvalid, capture mem_rdata into odata; go OUT.
- OUT(8): ovalid = 1 with stable odata and ochan. On ovalid && oready: ovalid = 0 next cycle; go IDLE.
- ivalid is ignored outside IDLE, so iready is never asserted there.
- mem_read and mem_write are never asserted simultaneously.
- Channels are fully independent: pointer and fill updates touch only the latched channel.
- A change on `delay` affects only subsequent accepts.
- Latency, accept to ovalid:
  - Bypass or priming path: 5 cycles minimum, with immediate busy handshakes.
  - Read path: write handshake + read handshake + rvalid wait.
- Illegal states: go to IDLE with strobes 0.

Optional Feature:
- Macro: MULTICHANNEL_DELAY_STORE_TIMEOUT_EN.
- Defined: a cycle counter runs in states 2-7 and resets on every state change. On reaching TIMEOUT_CYC:
  - Drop both strobes; set err (sticky until rst).
  - Output odata = 0 via OUT.
  - wptr and fill still advance only if WR_DONE completed.
- Undefined: no counter; err tied 0; the FSM waits indefinitely.

Test Plan:
- Reset, then CH_W=1, delay=3, ch0 samples 10, 20, 30, 40, 50 with an ideal memory model -> odata 0, 0, 0, 10, 20; mem_waddr 0..4; mem_raddr 0 then 1 on the 4th and 5th samples.
- Interleaved ch0=100 and ch1=-100 for 4 frames, delay=2 -> ch1 reads use addresses 0x800000+ (ADDR_W=24); outputs 0, 0, 100 / 0, 0, -100. No cross-channel leakage.
- wptr[0] preset near D-1 by feeding D-2 samples, delay=4 -> write address wraps to 0x000000; raddr = (wptr-4) mod D; data is correct across the wrap.
- delay=0, idata=0x7FFF -> odata 0x7FFF; no mem_read asserted. oready held low 10 cycles -> ovalid and odata stable throughout.
- mem_busy held high and lrclk toggled -> no strobe until busy=0 && lrclk=1. rst asserted during RD_ACK -> mem_read=0 and all outputs 0 the next cycle.
- With TIMEOUT_EN and TIMEOUT_CYC=16, mem_busy never rises after the write strobe -> mem_write drops at the 16th cycle; err=1; odata=0, ovalid=1.
